// File: rtl/gpu_vram_arbiter.sv
// gpu_vram_arbiter
//   Shares the single-port character RAM (COLS x ROWS cells, DW-bit codes)
//   between the text scanout engine and the GPU command path.
//   Scanout reads have absolute priority and a fixed 1-cycle latency.
//   Command reads/writes use a valid/ready handshake in free cycles.
//   An optional clear engine fills every cell with one value.
//
// Build option:
//   GPU_VRAM_CLEAR_EN  defined   -> clear engine and CLEAR state present
//                      undefined -> clear op accepted as a no-op, busy tied 0
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   scan_req/scan_addr          scanout read request
//   scan_valid/scan_data        scanout read result, 1 cycle after request
//   cmd_valid/cmd_ready         command handshake
//   cmd_op/cmd_addr/cmd_wdata   00 write, 01 read, 10 clear-all, 11 no-op
//   cmd_rvalid/cmd_rdata        command read result, 1 cycle after handshake
//   busy                        clear in progress
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   RAM port (1-cycle read)
module gpu_vram_arbiter #(
  parameter int COLS = 40,
  parameter int ROWS = 25,
  parameter int AW   = 10,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_valid,
  output logic [DW-1:0] scan_data,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_rvalid,
  output logic [DW-1:0] cmd_rdata,
  output logic          busy,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_CLR = 2'b10,
    OP_NOP = 2'b11
  } op_t;

  op_t  op;
  logic scan_hit;      // scan address inside the screen
  logic cmd_hit;       // command address inside the screen
  logic cmd_fire;      // command handshake this cycle
  logic clearing;
  logic scan_hit_q;
  logic cmd_hit_q;

  assign op       = op_t'(cmd_op);
  assign scan_hit = (scan_addr <= LAST_ADDR);
  assign cmd_hit  = (cmd_addr <= LAST_ADDR);

`ifdef GPU_VRAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] fill;

  assign clearing = (state == CLEAR);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      clr_ptr <= '0;
      fill    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire && op == OP_CLR) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            fill    <= cmd_wdata;
          end
        end
        CLEAR: begin
          // A scanout read steals the port; the pointer simply holds.
          if (!scan_req) begin
            if (clr_ptr == LAST_ADDR) begin
              state   <= IDLE;
              clr_ptr <= '0;
            end else begin
              clr_ptr <= clr_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign clearing = 1'b0;
`endif

  assign busy      = clearing;
  // Ready is gated by reset so nothing is accepted while reset is asserted.
  assign cmd_ready = reset && !scan_req && !clearing;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // RAM port mux: scanout, then clear engine, then command.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = scan_addr;
    ram_wdata = cmd_wdata;
    if (!reset) begin
      ram_en = 1'b0;
    end else if (scan_req) begin
      ram_en = scan_hit;
    end
`ifdef GPU_VRAM_CLEAR_EN
    else if (clearing) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_ptr;
      ram_wdata = fill;
    end
`endif
    else if (cmd_fire && cmd_hit) begin
      ram_addr = cmd_addr;
      case (op)
        OP_WR: begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
        OP_RD: ram_en = 1'b1;
        default: ram_en = 1'b0;
      endcase
    end
  end

  // Read-return tracking: out-of-range reads still complete but return 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_valid <= 1'b0;
      scan_hit_q <= 1'b0;
      cmd_rvalid <= 1'b0;
      cmd_hit_q  <= 1'b0;
    end else begin
      scan_valid <= scan_req;
      scan_hit_q <= scan_req && scan_hit;
      cmd_rvalid <= cmd_fire && (op == OP_RD);
      cmd_hit_q  <= cmd_fire && (op == OP_RD) && cmd_hit;
    end
  end

  // Only one read is in flight per cycle, so both paths share ram_rdata.
  assign scan_data = (scan_valid && scan_hit_q) ? ram_rdata : '0;
  assign cmd_rdata = (cmd_rvalid && cmd_hit_q) ? ram_rdata : '0;

endmodule

// File: doc/gpu_vram_arbiter.md
# gpu_vram_arbiter

Shares the single-port text/character RAM (40x25 cells, 8-bit codes) between the VGA text scanout and the GPU command path. Scanout reads always win; command reads and writes are admitted through a valid/ready handshake in idle cycles. A built-in clear engine fills the whole screen for the clear-screen command. Sits between the GPU command decoder, the text scanout engine and the character RAM.

## Interface
- COLS, 40, characters per line
- ROWS, 25, lines per screen
- AW, 10, address width (must hold COLS*ROWS-1)
- DW, 8, cell data width

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- scan_req  in  1  scanout read request this cycle
- scan_addr  in  AW  scanout cell address
- scan_valid  out  1  scan_data valid (one cycle after scan_req)
- scan_data  out  DW  scanout read data
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready
- cmd_op  in  2  00 write, 01 read, 10 clear-all, 11 no-op
- cmd_addr  in  AW  command cell address
- cmd_wdata  in  DW  write data / clear fill value
- cmd_rvalid  out  1  cmd_rdata valid
- cmd_rdata  out  DW  command read data
- busy  out  1  clear in progress
- ram_en, ram_we  out  1 each  RAM strobe / write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered, 1-cycle latency

## Operation
- FSM states: IDLE, CLEAR. Reset -> IDLE.
- Per-cycle priority: scan_req > clear-engine write > command.
- scan_req high: ram_en=1, ram_we=0, ram_addr=scan_addr; cmd_ready=0; clear engine stalls (pointer holds).
- IDLE, scan_req low: cmd_ready=1 (combinational). On handshake:
  - write: ram_we=1 at cmd_addr with cmd_wdata.
  - read: RAM read; cmd_rvalid=1 next cycle, cmd_rdata=ram_rdata.
  - clear: capture cmd_wdata as fill, pointer=0, -> CLEAR; no RAM access this cycle.
  - no-op: accepted, no RAM access.
- CLEAR: cmd_ready=0, busy=1. Each cycle without scan_req writes fill at pointer, pointer+1. After writing COLS*ROWS-1 -> IDLE.
- Address >= COLS*ROWS: command write dropped (ram_en=0), command read returns 0 with cmd_rvalid; scan read returns scan_data=0 with scan_valid.
- ram_en=0 in all cycles with no access; ram_wdata/ram_addr then don't-care.

## Timing
- Reset values: scan_valid=0, scan_data=0, cmd_rvalid=0, cmd_rdata=0, busy=0, ram_en=0, ram_we=0; cmd_ready forced 0 while reset low.
- Scan latency: exactly 1 cycle, every cycle, independent of command traffic.
- Command write: committed on handshake edge. Command read: data 1 cycle after handshake.
- Clear: minimum COLS*ROWS cycles (1000 default) plus one cycle per stalling scan_req; busy rises the cycle after handshake, falls the cycle after last write; cmd_ready returns with busy=0.
- Simultaneous scan_req and cmd_valid: scan served, command waits (cmd_valid must hold, inputs stable).
- Reset mid-clear: aborts immediately, IDLE, pointer 0; RAM left partially filled.

## Configuration
- GPU_VRAM_CLEAR_EN defined: clear engine and CLEAR state built as above.
- Not defined: no CLEAR state, no pointer; op 10 accepted as no-op, busy tied 0.

## Test plan
- Write 0x41 to addr 5, read addr 5 -> cmd_rvalid one cycle after handshake, cmd_rdata=0x41.
- scan_req held high 10 cycles with cmd_valid high -> cmd_ready=0 throughout; scan_valid every cycle 1 later; write lands the cycle scan_req drops.
- Clear fill 0x20, no scanout -> busy exactly 1000 cycles; addrs 0, 500, 999 read 0x20.
- Clear with scan_req every other cycle -> busy ~2000 cycles; all 1000 cells 0x20; scan data never late.
- Write to addr 1000 -> no RAM write; read addr 1000 -> cmd_rdata=0.
- Reset low at clear cycle 300 -> busy=0 immediately; cell 299 = fill, cell 300 unchanged.
